branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline, sitting beside the PC register in IF. It replaces the fixed always-not-taken `pc + 4` next-PC path with a gshare direction predictor and a tagged branch target buffer (BTB). The EX stage trains the predictor and reports mispredictions. The block keeps a speculative global history register (GHR) and repairs it on redirect.

## Interface
Parameters:
- XLEN, 32, address/data width
- BTB_ENTRIES, 32, BTB and pattern-history-table (PHT) entries; power of two, ≥ 4
- GHR_BITS, 5, global history length; 1 ≤ GHR_BITS ≤ log2(BTB_ENTRIES)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- if_pc  in  XLEN  PC of the instruction being fetched
- if_advance  in  1  fetch proceeds this cycle; low during stall
- pred_taken  out  1  predicted taken
- pred_next_pc  out  XLEN  next fetch PC: pred_target if taken, else if_pc + 4
- pred_ghr  out  GHR_BITS  GHR value used for this prediction; carried down the pipe to EX
- upd_valid  in  1  resolved control instruction in EX
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_is_cond  in  1  1 = conditional branch, 0 = jal/jalr
- upd_taken  in  1  actual direction
- upd_target  in  XLEN  actual target
- upd_ghr  in  GHR_BITS  pred_ghr that travelled with the instruction
- upd_mispredict  in  1  EX redirect (wrong direction or wrong target)

## Operation
- IDX = log2(BTB_ENTRIES). BTB index = pc[IDX+1:2]. Tag = pc[XLEN-1:IDX+2].
- PHT index = pc[IDX+1:2] XOR zero-extended GHR.
- BTB entry: valid, tag, target[XLEN-1:0], is_jump.
- PHT entry: 2-bit saturating counter. 00 = strong not-taken (SNT), 01 = weak not-taken (WNT), 10 = weak taken (WT), 11 = strong taken (ST).
- Prediction is combinational. hit = valid && tag match. pred_taken = hit && (is_jump || ctr[1]).
- Speculative GHR: on if_advance && hit && !is_jump, GHR <= {GHR[GHR_BITS-2:0], pred_taken}. No shift otherwise.
- Update on upd_valid:
  - upd_is_cond: PHT[upd_pc index XOR upd_ghr] increments if taken, else decrements, saturating at 00/11.
  - upd_taken: BTB[index] <= {1, tag, upd_target, !upd_is_cond}. This allocates or overwrites and replaces any aliasing tag.
  - Not-taken conditional branch: BTB untouched.
- Recovery on upd_valid && upd_mispredict:
  - Conditional: GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}.
  - Jump: GHR <= upd_ghr.
  - Recovery overrides a same-cycle speculative shift.
- upd_mispredict without upd_valid is ignored.

## Timing
- Prediction: zero-cycle latency, pure function of if_pc and current state.
- Update/recovery: takes effect at the next rising edge; first visible to the prediction in the following cycle.
- Same-cycle read and write of one BTB/PHT entry: the prediction sees the pre-update value. No bypass.
- Reset values (asynchronous, immediate):
  - All BTB valid = 0; targets and tags = 0.
  - All PHT counters = 01 (WNT).
  - GHR = 0.
  - Hence pred_taken = 0, pred_next_pc = if_pc + 4, pred_ghr = 0.
- Reset mid-update discards the update. The first post-reset edge with upd_valid is processed normally.
- pc + 4 wraps modulo 2^XLEN.

## Structure
- Shared package cpu_pkg:
  - XLEN default.
  - Counter encodings CTR_SNT/CTR_WNT/CTR_WT/CTR_ST.
  - Function ctr_next(ctr, taken).
- Sub-module bp_btb: tag/target/valid/is_jump arrays with combinational lookup and single write port.
- PHT, GHR and next-PC mux stay in branch_predictor.

## Test plan
- Reset, then if_pc=0x40 with no updates -> pred_taken=0, pred_next_pc=0x44, pred_ghr=0.
- Train a conditional branch at 0x100 with target 0x80, taken twice with upd_ghr=0, GHR held 0 -> after the first update PHT=10 and prediction at 0x100 with GHR=0 gives taken/0x80; after the second PHT=11; two not-taken updates then return the counter to 01, predicting not-taken.
- jal at 0x200 with target 0x300, one update -> next cycle pred_taken=1 and pred_next_pc=0x300, independent of the PHT counter.
- BTB_ENTRIES=32: train 0x100 taken, then if_pc=0x180 (same index, different tag) -> miss, pred_next_pc=0x184, GHR unchanged by if_advance.
- GHR=10110 with speculative shift and mispredict (upd_ghr=00011, upd_taken=0, conditional) in the same cycle -> GHR=00110 next cycle.
- Assert reset asynchronously between clock edges during an update -> outputs return to reset values immediately; the training is not retained.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width and 2-bit direction counter helpers.
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Saturating step of a 2-bit direction counter toward the resolved outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    if (taken) r = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       r = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped tagged branch target buffer: combinational lookup, one write port.
module bp_btb
  import cpu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int ENTRIES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] i_rd_pc,
  output logic            o_hit,
  output logic            o_is_jump,
  output logic [XLEN-1:0] o_target,
  input  logic            i_wr_en,
  input  logic [XLEN-1:0] i_wr_pc,
  input  logic [XLEN-1:0] i_wr_target,
  input  logic            i_wr_is_jump
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_is_jump;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];

  logic [IDX-1:0]   w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [IDX-1:0]   w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;
  logic             w_unused;

  assign w_rd_idx = i_rd_pc[IDX+1:2];
  assign w_rd_tag = i_rd_pc[XLEN-1:IDX+2];
  assign w_wr_idx = i_wr_pc[IDX+1:2];
  assign w_wr_tag = i_wr_pc[XLEN-1:IDX+2];
  // Instruction-aligned PCs: the byte-offset bits carry no information here.
  assign w_unused = &{1'b0, i_rd_pc[1:0], i_wr_pc[1:0]};

  assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_is_jump = r_is_jump[w_rd_idx];
  assign o_target  = r_target[w_rd_idx];

  // Allocate or overwrite the indexed entry; an aliasing tag is simply replaced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= '0;
      r_is_jump <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_valid[w_wr_idx]   <= 1'b1;
      r_is_jump[w_wr_idx] <= i_wr_is_jump;
      r_tag[w_wr_idx]     <= w_wr_tag;
      r_target[w_wr_idx]  <= i_wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// gshare direction predictor plus BTB; keeps a speculative GHR repaired on EX redirect.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int BTB_ENTRIES = 32,
  parameter int GHR_BITS    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     if_pc,
  input  logic                if_advance,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_next_pc,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [XLEN-1:0]     upd_pc,
  input  logic                upd_is_cond,
  input  logic                upd_taken,
  input  logic [XLEN-1:0]     upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_mispredict
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  logic [1:0]          r_pht [BTB_ENTRIES];
  logic [GHR_BITS-1:0] r_ghr;

  logic            w_btb_hit;
  logic            w_btb_jump;
  logic [XLEN-1:0] w_btb_target;
  logic [IDX-1:0]  w_pht_rd_idx;
  logic [IDX-1:0]  w_pht_wr_idx;
  logic [1:0]      w_pht_ctr;

  bp_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .reset        (reset),
    .i_rd_pc      (if_pc),
    .o_hit        (w_btb_hit),
    .o_is_jump    (w_btb_jump),
    .o_target     (w_btb_target),
    .i_wr_en      (upd_valid && upd_taken),
    .i_wr_pc      (upd_pc),
    .i_wr_target  (upd_target),
    .i_wr_is_jump (!upd_is_cond)
  );

  // History is zero-extended to the index width before hashing.
  assign w_pht_rd_idx = if_pc[IDX+1:2] ^ IDX'(r_ghr);
  assign w_pht_wr_idx = upd_pc[IDX+1:2] ^ IDX'(upd_ghr);
  assign w_pht_ctr    = r_pht[w_pht_rd_idx];

  assign pred_taken   = w_btb_hit && (w_btb_jump || w_pht_ctr[1]);
  assign pred_next_pc = pred_taken ? w_btb_target : if_pc + XLEN'(4);
  assign pred_ghr     = r_ghr;

  // Train the direction counter of each resolved conditional branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_pht[i] <= CTR_WNT;
    end else if (upd_valid && upd_is_cond) begin
      r_pht[w_pht_wr_idx] <= ctr_next(r_pht[w_pht_wr_idx], upd_taken);
    end
  end

  // Speculative history shift on fetched conditional hits; EX repair takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (upd_valid && upd_mispredict) begin
      r_ghr <= upd_is_cond ? GHR_BITS'({upd_ghr, upd_taken}) : upd_ghr;
    end else if (if_advance && w_btb_hit && !w_btb_jump) begin
      r_ghr <= GHR_BITS'({r_ghr, pred_taken});
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a table model.
module tb_branch_predictor;

  localparam int XLEN = 32;
  localparam int NENT = 32;
  localparam int GB   = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] if_pc = '0;
  logic            if_advance = 1'b0;
  logic            pred_taken;
  logic [XLEN-1:0] pred_next_pc;
  logic [GB-1:0]   pred_ghr;
  logic            upd_valid = 1'b0;
  logic [XLEN-1:0] upd_pc = '0;
  logic            upd_is_cond = 1'b0;
  logic            upd_taken = 1'b0;
  logic [XLEN-1:0] upd_target = '0;
  logic [GB-1:0]   upd_ghr = '0;
  logic            upd_mispredict = 1'b0;

  int total = 0;
  int bad = 0;

  branch_predictor #(.XLEN(XLEN), .BTB_ENTRIES(NENT), .GHR_BITS(GB)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_advance(if_advance),
    .pred_taken(pred_taken), .pred_next_pc(pred_next_pc), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr),
    .upd_mispredict(upd_mispredict)
  );

  always #5 clk = ~clk;

  // Reference model: plain tables indexed by word address modulo table size.
  bit              m_valid [NENT];
  bit              m_jmp   [NENT];
  logic [XLEN-1:0] m_tag   [NENT];
  logic [XLEN-1:0] m_tgt   [NENT];
  int              m_pht   [NENT];
  int              m_ghr;

  function automatic int m_idx(logic [XLEN-1:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  function automatic bit m_hit(logic [XLEN-1:0] pc);
    int i = m_idx(pc);
    return m_valid[i] && (m_tag[i] == pc / (4 * NENT));
  endfunction

  function automatic bit m_taken(logic [XLEN-1:0] pc);
    int i = m_idx(pc);
    if (!m_hit(pc)) return 1'b0;
    if (m_jmp[i]) return 1'b1;
    return m_pht[i ^ m_ghr] >= 2;
  endfunction

  function automatic logic [XLEN-1:0] m_next(logic [XLEN-1:0] pc);
    if (m_taken(pc)) return m_tgt[m_idx(pc)];
    return pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 0; m_jmp[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_pht[i] = 1;
    end
    m_ghr = 0;
  endtask

  // One clock: capture the pre-edge prediction, let the edge pass, advance the model.
  task automatic cycle();
    bit pt, hit, jmp;
    int ng, pi;
    pt  = m_taken(if_pc);
    hit = m_hit(if_pc);
    jmp = m_jmp[m_idx(if_pc)];
    @(posedge clk);
    if (!reset) begin
      ng = m_ghr;
      if (if_advance && hit && !jmp) ng = (m_ghr * 2 + int'(pt)) % (1 << GB);
      if (upd_valid && upd_is_cond) begin
        pi = m_idx(upd_pc) ^ int'(upd_ghr);
        if (upd_taken) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
        else           m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
      end
      if (upd_valid && upd_taken) begin
        m_valid[m_idx(upd_pc)] = 1;
        m_jmp[m_idx(upd_pc)]   = !upd_is_cond;
        m_tag[m_idx(upd_pc)]   = upd_pc / (4 * NENT);
        m_tgt[m_idx(upd_pc)]   = upd_target;
      end
      if (upd_valid && upd_mispredict)
        ng = upd_is_cond ? (int'(upd_ghr) * 2 + int'(upd_taken)) % (1 << GB) : int'(upd_ghr);
      m_ghr = ng;
    end
    #1;
  endtask

  task automatic set_upd(bit v, logic [XLEN-1:0] pc, bit cond, bit tk,
                         logic [XLEN-1:0] tgt, logic [GB-1:0] g, bit mis);
    upd_valid = v; upd_pc = pc; upd_is_cond = cond; upd_taken = tk;
    upd_target = tgt; upd_ghr = g; upd_mispredict = mis;
  endtask

  task automatic test_reset();
    if_pc = 32'h40; if_advance = 1'b0;
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%0b exp=0", pred_taken); end
    total++; if (pred_next_pc !== 32'h44) begin bad++; $display("FAIL reset_next got=%h exp=00000044", pred_next_pc); end
    total++; if (pred_ghr !== 5'd0) begin bad++; $display("FAIL reset_ghr got=%b exp=00000", pred_ghr); end
  endtask

  task automatic test_cond_training();
    if_pc = 32'h100; if_advance = 1'b0;
    set_upd(1, 32'h100, 1, 1, 32'h80, 5'd0, 0);
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL cond_same_cycle got=%0b exp=0", pred_taken); end
    cycle();
    upd_valid = 1'b0; #1;
    total++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h80)
      begin bad++; $display("FAIL cond_wt got=%0b/%h exp=1/00000080", pred_taken, pred_next_pc); end
    upd_valid = 1'b1; cycle();
    upd_valid = 1'b1; upd_taken = 1'b0; cycle();
    upd_valid = 1'b0; #1;
    total++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h80)
      begin bad++; $display("FAIL cond_st_then_nt got=%0b/%h exp=1/00000080", pred_taken, pred_next_pc); end
    upd_valid = 1'b1; cycle();
    upd_valid = 1'b0; #1;
    total++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h104)
      begin bad++; $display("FAIL cond_back_to_wnt got=%0b/%h exp=0/00000104", pred_taken, pred_next_pc); end
    total++; if (pred_ghr !== 5'd0) begin bad++; $display("FAIL cond_ghr_held got=%b exp=00000", pred_ghr); end
  endtask

  task automatic test_jal();
    if_pc = 32'h200;
    set_upd(1, 32'h200, 0, 1, 32'h300, 5'd0, 0);
    cycle();
    upd_valid = 1'b0; #1;
    total++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h300)
      begin bad++; $display("FAIL jal_pred got=%0b/%h exp=1/00000300", pred_taken, pred_next_pc); end
  endtask

  task automatic test_alias();
    set_upd(1, 32'h100, 1, 1, 32'h80, 5'd0, 0);
    cycle();
    upd_valid = 1'b0;
    if_pc = 32'h180; if_advance = 1'b1; #1;
    total++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h184)
      begin bad++; $display("FAIL alias_miss got=%0b/%h exp=0/00000184", pred_taken, pred_next_pc); end
    cycle();
    if_advance = 1'b0; #1;
    total++; if (pred_ghr !== 5'd0) begin bad++; $display("FAIL alias_ghr got=%b exp=00000", pred_ghr); end
  endtask

  task automatic test_recovery();
    if_advance = 1'b0;
    set_upd(1, 32'h504, 0, 1, 32'h600, 5'b10110, 1);
    cycle();
    #1;
    total++; if (pred_ghr !== 5'b10110) begin bad++; $display("FAIL jump_repair got=%b exp=10110", pred_ghr); end
    if_pc = 32'h100; if_advance = 1'b1;
    set_upd(1, 32'h108, 1, 0, 32'h0, 5'b00011, 1);
    cycle();
    upd_valid = 1'b0; if_advance = 1'b0; #1;
    total++; if (pred_ghr !== 5'b00110) begin bad++; $display("FAIL repair_overrides got=%b exp=00110", pred_ghr); end
    set_upd(0, 32'h108, 1, 1, 32'h0, 5'b11111, 1);
    cycle();
    upd_mispredict = 1'b0; #1;
    total++; if (pred_ghr !== 5'b00110) begin bad++; $display("FAIL mispredict_no_valid got=%b exp=00110", pred_ghr); end
  endtask

  task automatic test_async_reset();
    if_pc = 32'h504; if_advance = 1'b0; #1;
    total++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h600)
      begin bad++; $display("FAIL pre_reset_jal got=%0b/%h exp=1/00000600", pred_taken, pred_next_pc); end
    set_upd(1, 32'h700, 0, 1, 32'h900, 5'd0, 0);
    #2 reset = 1'b1;
    #1;
    total++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h508 || pred_ghr !== 5'd0)
      begin bad++; $display("FAIL async_reset got=%0b/%h/%b exp=0/00000508/00000", pred_taken, pred_next_pc, pred_ghr); end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    upd_valid = 1'b0; if_pc = 32'h700; #1;
    total++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h704)
      begin bad++; $display("FAIL update_discarded got=%0b/%h exp=0/00000704", pred_taken, pred_next_pc); end
    upd_valid = 1'b1;
    cycle();
    upd_valid = 1'b0; #1;
    total++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h900)
      begin bad++; $display("FAIL post_reset_update got=%0b/%h exp=1/00000900", pred_taken, pred_next_pc); end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] pool [8];
    pool[0] = 32'h100; pool[1] = 32'h180; pool[2] = 32'h104; pool[3] = 32'h200;
    pool[4] = 32'h2004; pool[5] = 32'hFFFF_FFFC; pool[6] = 32'h7C; pool[7] = 32'h1000_0100;
    for (int n = 0; n < 600; n++) begin
      if_pc      = pool[$urandom_range(0, 7)];
      if_advance = 1'($urandom_range(0, 1));
      set_upd(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC,
              GB'($urandom_range(0, 31)), 1'($urandom_range(0, 3) == 0));
      #1;
      total++; if (pred_taken !== m_taken(if_pc))
        begin bad++; $display("FAIL rnd_taken pc=%h got=%0b exp=%0b", if_pc, pred_taken, m_taken(if_pc)); end
      total++; if (pred_next_pc !== m_next(if_pc))
        begin bad++; $display("FAIL rnd_next pc=%h got=%h exp=%h", if_pc, pred_next_pc, m_next(if_pc)); end
      total++; if (int'(pred_ghr) != m_ghr)
        begin bad++; $display("FAIL rnd_ghr got=%0d exp=%0d", pred_ghr, m_ghr); end
      cycle();
    end
    set_upd(0, '0, 0, 0, '0, '0, 0);
    if_advance = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    test_cond_training();
    test_jal();
    test_alias();
    test_recovery();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
